// File: rtl/sigen_pkg.sv
// sigen_pkg: shared types and defaults for the square-wave generator and measurement blocks
package sigen_pkg;
  typedef enum logic [1:0] {IDLE, MEAS_HIGH, MEAS_LOW} meas_state_t;
  localparam int CLK_HZ = 125_000_000;
  localparam int DEF_CNT_W = 30;
endpackage

// File: rtl/sigmeas_sync.sv
// sigmeas_sync: multi-flop synchronizer with a history flop for rise/fall detection
module sigmeas_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_async,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] s;
  logic hist;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s <= '0;
      hist <= 1'b0;
    end else begin
      s <= {s[SYNC_STAGES-2:0], d_async};
      hist <= s[SYNC_STAGES-1];
    end
  end
  assign q = s[SYNC_STAGES-1];
  assign rise = q & ~hist;
  assign fall = ~q & hist;
endmodule

// File: rtl/sigmeas_rx.sv
// sigmeas_rx: measures period and high time of an external square wave and flags loss of signal
module sigmeas_rx
  import sigen_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int TIMEOUT = CLK_HZ,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pmod_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             no_signal
);
  localparam logic [CNT_W-1:0] CMAX = CNT_W'(TIMEOUT - 1);
  meas_state_t state;
  logic [CNT_W-1:0] cnt, hi_tmp;
  logic synced, rise, fall, at_max, held;
  sigmeas_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk,
    .rst_n,
    .d_async(pmod_in),
    .q(synced),
    .rise,
    .fall
  );
  assign at_max = cnt == CMAX;
  // input still sits at the level the current state expects, i.e. no edge this cycle
  assign held = synced == (state == MEAS_HIGH);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      hi_tmp <= '0;
      period <= '0;
      high_time <= '0;
      meas_valid <= 1'b0;
      no_signal <= 1'b1;
    end else begin
      meas_valid <= 1'b0;
      cnt <= rise ? '0 : at_max ? cnt : cnt + 1'b1;
      case (state)
        IDLE: if (rise) state <= MEAS_HIGH;
        MEAS_HIGH:
          if (fall) begin
            hi_tmp <= cnt + 1'b1;
            state <= MEAS_LOW;
          end else if (at_max && held) begin
            no_signal <= 1'b1;
            state <= IDLE;
          end
        MEAS_LOW:
          if (rise) begin
            period <= cnt + 1'b1;
            high_time <= hi_tmp;
            meas_valid <= 1'b1;
            no_signal <= 1'b0;
            state <= MEAS_HIGH;
          end else if (at_max && held) begin
            no_signal <= 1'b1;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sigmeas_rx.sv
// tb_sigmeas_rx: directed checks of sigmeas_rx with short (16) and long (1000) timeouts
module tb_sigmeas_rx;
  logic clk, rst_n, pmod_in;
  logic [11:0] p_a, h_a, p_b, h_b;
  logic v_a, ns_a, v_b, ns_b;
  int vectors = 0, miscompares = 0;
  int cyc = 0, rcyc = 0;
  int nv_a = 0, lp_a = 0, lh_a = 0, vc_a = 0, nsc_a = 0, dbl_a = 0;
  int nv_b = 0, lp_b = 0, lh_b = 0, vc_b = 0, nsc_b = 0, dbl_b = 0;
  logic pv_a = 0, pns_a = 1, pv_b = 0, pns_b = 1;
  int na, nb;

  sigmeas_rx #(.CNT_W(12), .TIMEOUT(16), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .pmod_in(pmod_in),
    .period(p_a), .high_time(h_a), .meas_valid(v_a), .no_signal(ns_a)
  );
  sigmeas_rx #(.CNT_W(12), .TIMEOUT(1000), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .pmod_in(pmod_in),
    .period(p_b), .high_time(h_b), .meas_valid(v_b), .no_signal(ns_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (v_a) begin nv_a++; lp_a = int'(p_a); lh_a = int'(h_a); vc_a = cyc; end
    if (v_a && pv_a) dbl_a++;
    if (ns_a && !pns_a) nsc_a = cyc;
    pv_a = v_a;
    pns_a = ns_a;
    if (v_b) begin nv_b++; lp_b = int'(p_b); lh_b = int'(h_b); vc_b = cyc; end
    if (v_b && pv_b) dbl_b++;
    if (ns_b && !pns_b) nsc_b = cyc;
    pv_b = v_b;
    pns_b = ns_b;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wave(input int h, input int l);
    pmod_in = 1'b1;
    rcyc = cyc;
    repeat (h) tick();
    pmod_in = 1'b0;
    repeat (l) tick();
  endtask

  initial begin
    rst_n = 1'b0;
    pmod_in = 1'b0;
    repeat (6) begin tick(); pmod_in = ~pmod_in; end
    chk("rst_period_a", p_a, 0);
    chk("rst_high_a", h_a, 0);
    chk("rst_valid_a", v_a, 0);
    chk("rst_nosig_a", ns_a, 1);
    chk("rst_period_b", p_b, 0);
    chk("rst_nosig_b", ns_b, 1);
    chk("rst_valid_cnt", nv_a + nv_b, 0);
    pmod_in = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    // duty 3/7 and latency
    wave(3, 7);
    chk("first_rise_no_valid", nv_a, 0);
    chk("first_rise_nosig", ns_a, 1);
    wave(3, 7);
    chk("duty_valid_cnt", nv_a, 1);
    chk("duty_period", lp_a, 10);
    chk("duty_high", lh_a, 3);
    chk("valid_latency", vc_a - rcyc, 3);
    chk("duty_nosig", ns_a, 0);
    chk("duty_period_b", lp_b, 10);
    wave(3, 7);
    wave(3, 7);
    chk("repeat_valid_cnt", nv_a, 3);
    chk("repeat_period", lp_a, 10);
    // stop toggling: timeout
    repeat (1010) tick();
    chk("timeout_nosig_a", ns_a, 1);
    chk("timeout_delay_a", nsc_a - vc_a, 16);
    chk("timeout_nosig_b", ns_b, 1);
    chk("timeout_delay_b", nsc_b - vc_b, 1000);
    chk("timeout_hold_period", p_a, 10);
    chk("timeout_hold_high", h_a, 3);
    chk("timeout_hold_period_b", p_b, 10);
    na = nv_a;
    wave(3, 7);
    chk("restart_no_valid", nv_a, na);
    chk("restart_nosig_kept", ns_a, 1);
    wave(3, 7);
    chk("restart_valid", nv_a, na + 1);
    chk("restart_nosig_clr", ns_a, 0);
    chk("restart_nosig_clr_b", ns_b, 0);
    // boundary around TIMEOUT=16
    wave(8, 8);
    wave(8, 8);
    chk("bound16_period", lp_a, 16);
    chk("bound16_high", lh_a, 8);
    chk("bound16_nosig", ns_a, 0);
    wave(8, 9);
    na = nv_a;
    chk("bound16_again", lp_a, 16);
    wave(8, 9);
    chk("bound17_no_valid", nv_a, na);
    chk("bound17_nosig", ns_a, 1);
    chk("bound17_period_b", lp_b, 17);
    chk("bound17_high_b", lh_b, 8);
    // constant high
    nb = nv_b;
    pmod_in = 1'b1;
    repeat (1010) tick();
    chk("const_high_valid_b", nv_b, nb + 1);
    chk("const_high_nosig_b", ns_b, 1);
    chk("const_high_nosig_a", ns_a, 1);
    pmod_in = 1'b0;
    repeat (5) tick();
    na = nv_a;
    nb = nv_b;
    wave(3, 7);
    chk("after_high_no_valid_a", nv_a, na);
    chk("after_high_no_valid_b", nv_b, nb);
    wave(3, 7);
    chk("after_high_valid_b", nv_b, nb + 1);
    chk("after_high_period_b", lp_b, 10);
    chk("after_high_nosig_b", ns_b, 0);
    chk("after_high_valid_a", nv_a, na + 1);
    // reset while in MEAS_LOW
    na = nv_a;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_period", p_a, 0);
    chk("midrst_high", h_a, 0);
    chk("midrst_valid", v_a, 0);
    chk("midrst_nosig", ns_a, 1);
    chk("midrst_period_b", p_b, 0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    wave(3, 7);
    chk("midrst_no_valid", nv_a, na);
    wave(3, 7);
    chk("midrst_resume_valid", nv_a, na + 1);
    chk("midrst_resume_period", lp_a, 10);
    chk("midrst_resume_high", lh_a, 3);
    chk("midrst_resume_nosig", ns_a, 0);
    // minimum period of 2
    na = nv_a;
    repeat (4) wave(1, 1);
    pmod_in = 1'b0;
    repeat (5) tick();
    chk("p2_valid_cnt", nv_a, na + 4);
    chk("p2_period", lp_a, 2);
    chk("p2_high", lh_a, 1);
    chk("no_back_to_back_a", dbl_a, 0);
    chk("no_back_to_back_b", dbl_b, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
